// File: rtl/accel_spi_responder_pkg.sv
// Shared constants for the accelerometer SPI responder:
// opcodes, register map, reset values and FSM states.
package accel_spi_responder_pkg;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
  localparam logic [7:0] ADDR_PARTID    = 8'h02;
  localparam logic [7:0] ADDR_XDATA     = 8'h08;
  localparam logic [7:0] ADDR_YDATA     = 8'h09;
  localparam logic [7:0] ADDR_ZDATA     = 8'h0A;
  localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H   = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L   = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H   = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L   = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H   = 8'h13;
  localparam logic [7:0] ADDR_FILTER    = 8'h2C;
  localparam logic [7:0] ADDR_POWER     = 8'h2D;

  localparam logic [7:0] FILTER_CTL_RST = 8'h13;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_e;

  function automatic logic [7:0] hi_byte(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

endpackage

// File: rtl/accel_spi_responder_if.sv
// SPI link between the movement master and the
// accelerometer responder.
interface accel_spi_responder_if;
  logic sclk;
  logic csn;
  logic mosi;
  logic miso;

  modport master (
    output sclk, csn, mosi,
    input  miso
  );

  modport slave (
    input  sclk, csn, mosi,
    output miso
  );
endinterface

// File: rtl/accel_spi_responder_spi_edge_sync.sv
// Brings an asynchronous SPI line into the clk domain
// and flags its rising and falling edges.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw input along the chain; remember last level
  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(din);
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-history flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 responder emulating the accelerometer
// register view from parallel X/Y/Z samples.
module accel_spi_responder
  import accel_spi_responder_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic                  clk,
  input  logic                  rst,
  accel_spi_responder_if.slave  spi,
  input  logic [11:0]           x_in,
  input  logic [11:0]           y_in,
  input  logic [11:0]           z_in,
  output logic                  measure,
  output logic                  frame_done
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_levels;

  // csn resets low so a frame already in progress at reset
  // produces no fall edge until csn has been seen high.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(spi.sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csn (
    .clk(clk), .rst(rst), .din(spi.csn),
    .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi.mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused_levels = ^{sclk_lvl, csn_lvl, mosi_rise, mosi_fall};

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  tx_q, tx_d;
  logic        wr_q, wr_d;
  logic        addr_done_q, addr_done_d;
  logic        miso_q, miso_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  filter_q, filter_d;
  logic [7:0]  power_q, power_d;
  logic [11:0] shx_q, shx_d;
  logic [11:0] shy_q, shy_d;
  logic [11:0] shz_q, shz_d;

  logic [7:0]  rx_byte;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;

  assign measure    = (power_q[1:0] == 2'b10);
  assign spi.miso   = miso_q;
  assign frame_done = frame_done_q;

  // Register read mux for the byte about to be shifted out
  always_comb begin
    rx_byte = {shift_q[6:0], mosi_lvl};
    rd_addr = (state_q == ST_ADDR) ? rx_byte : ptr_q + 8'd1;
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DEVID_AD:  rd_data = DEVID_AD;
      ADDR_DEVID_MST: rd_data = DEVID_MST;
      ADDR_PARTID:    rd_data = PARTID;
      ADDR_XDATA:     rd_data = measure ? shx_q[11:4] : 8'h00;
      ADDR_YDATA:     rd_data = measure ? shy_q[11:4] : 8'h00;
      ADDR_ZDATA:     rd_data = measure ? shz_q[11:4] : 8'h00;
      ADDR_XDATA_L:   rd_data = measure ? shx_q[7:0] : 8'h00;
      ADDR_XDATA_H:   rd_data = measure ? hi_byte(shx_q) : 8'h00;
      ADDR_YDATA_L:   rd_data = measure ? shy_q[7:0] : 8'h00;
      ADDR_YDATA_H:   rd_data = measure ? hi_byte(shy_q) : 8'h00;
      ADDR_ZDATA_L:   rd_data = measure ? shz_q[7:0] : 8'h00;
      ADDR_ZDATA_H:   rd_data = measure ? hi_byte(shz_q) : 8'h00;
      ADDR_FILTER:    rd_data = filter_q;
      ADDR_POWER:     rd_data = power_q;
      default:        rd_data = 8'h00;
    endcase
  end

  // Frame FSM: csn edges take priority over sclk edges
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    tx_d         = tx_q;
    wr_d         = wr_q;
    addr_done_d  = addr_done_q;
    miso_d       = miso_q;
    frame_done_d = 1'b0;
    filter_d     = filter_q;
    power_d      = power_q;
    shx_d        = shx_q;
    shy_d        = shy_q;
    shz_d        = shz_q;
    if (csn_rise) begin
      state_d      = ST_IDLE;
      miso_d       = 1'b0;
      addr_done_d  = 1'b0;
      frame_done_d = addr_done_q;
    end else if (csn_fall) begin
      state_d     = ST_CMD;
      bit_cnt_d   = 3'd0;
      miso_d      = 1'b0;
      addr_done_d = 1'b0;
      shx_d       = x_in;
      shy_d       = y_in;
      shz_d       = z_in;
    end else if (sclk_rise && state_q != ST_IDLE) begin
      shift_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          ST_CMD: begin
            if (rx_byte == CMD_WR) begin
              wr_d    = 1'b1;
              state_d = ST_ADDR;
            end else if (rx_byte == CMD_RD) begin
              wr_d    = 1'b0;
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
          ST_ADDR: begin
            ptr_d       = rx_byte;
            state_d     = ST_DATA;
            addr_done_d = 1'b1;
            tx_d        = rd_data;
          end
          ST_DATA: begin
            ptr_d = ptr_q + 8'd1;
            if (wr_q) begin
              if (ptr_q == ADDR_FILTER) filter_d = rx_byte;
              if (ptr_q == ADDR_POWER)  power_d  = rx_byte;
            end else begin
              tx_d = rd_data;
            end
          end
          default: ;
        endcase
      end
    end else if (sclk_fall && state_q == ST_DATA && !wr_q) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end
  end

  // State and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      ptr_q        <= 8'h00;
      tx_q         <= 8'h00;
      wr_q         <= 1'b0;
      addr_done_q  <= 1'b0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
      filter_q     <= FILTER_CTL_RST;
      power_q      <= POWER_CTL_RST;
      shx_q        <= 12'h000;
      shy_q        <= 12'h000;
      shz_q        <= 12'h000;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      tx_q         <= tx_d;
      wr_q         <= wr_d;
      addr_done_q  <= addr_done_d;
      miso_q       <= miso_d;
      frame_done_q <= frame_done_d;
      filter_q     <= filter_d;
      power_q      <= power_d;
      shx_q        <= shx_d;
      shy_q        <= shy_d;
      shz_q        <= shz_d;
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: table of
// register frames plus hand-written corner sequences.
module tb_accel_spi_responder;
  import accel_spi_responder_pkg::*;

  localparam int HALF = 5;

  typedef logic [3:0][7:0] bytes_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [2:0] n;
    bytes_t     d;
    logic       meas;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] x_in, y_in, z_in;
  logic        measure, frame_done;

  accel_spi_responder_if spi_if();

  accel_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .spi(spi_if),
    .x_in(x_in),
    .y_in(y_in),
    .z_in(z_in),
    .measure(measure),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;

  always @(posedge clk) if (frame_done) fd_cnt++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b, output logic r);
    spi_if.mosi = b;
    clks(HALF);
    spi_if.sclk = 1'b1;
    r = spi_if.miso;
    clks(HALF);
    spi_if.sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) sbit(tx[i], rx[i]);
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] addr,
                       input int n, input bytes_t wd,
                       output bytes_t rd);
    logic [7:0] junk;
    rd = '0;
    spi_if.csn = 1'b0;
    clks(6);
    xfer(cmd, junk);
    xfer(addr, junk);
    for (int i = 0; i < n; i++) xfer(wd[i], rd[i]);
    clks(4);
    spi_if.csn = 1'b1;
    clks(10);
  endtask

  function automatic vec_t mk(input logic [7:0] c, input logic [7:0] a,
                              input logic [2:0] n,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic m);
    vec_t v;
    v.cmd  = c;
    v.addr = a;
    v.n    = n;
    v.d[0] = b0;
    v.d[1] = b1;
    v.d[2] = b2;
    v.d[3] = b3;
    v.meas = m;
    return v;
  endfunction

  vec_t   tbl [16];
  bytes_t rd;
  logic [7:0] r0, r1, junk;
  logic       rb;
  int         fd0;

  initial begin
    tbl[0]  = mk(CMD_RD, 8'h00, 3, 8'hAD, 8'h1D, 8'hF2, 8'h00, 1'b0);
    tbl[1]  = mk(CMD_RD, 8'h2C, 2, 8'h13, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[2]  = mk(CMD_RD, 8'h08, 3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[3]  = mk(CMD_RD, 8'h0E, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[4]  = mk(CMD_WR, 8'h2D, 1, 8'h02, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[5]  = mk(CMD_RD, 8'h2D, 1, 8'h02, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[6]  = mk(CMD_RD, 8'h08, 3, 8'hF8, 8'h12, 8'h80, 8'h00, 1'b1);
    tbl[7]  = mk(CMD_RD, 8'h0E, 4, 8'h85, 8'hFF, 8'h23, 8'h01, 1'b1);
    tbl[8]  = mk(CMD_RD, 8'h12, 2, 8'h00, 8'hF8, 8'h00, 8'h00, 1'b1);
    tbl[9]  = mk(CMD_RD, 8'hFF, 2, 8'h00, 8'hAD, 8'h00, 8'h00, 1'b1);
    tbl[10] = mk(CMD_RD, 8'h2E, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[11] = mk(CMD_WR, 8'h2C, 2, 8'h07, 8'h03, 8'h00, 8'h00, 1'b0);
    tbl[12] = mk(CMD_RD, 8'h2C, 2, 8'h07, 8'h03, 8'h00, 8'h00, 1'b0);
    tbl[13] = mk(CMD_RD, 8'h12, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[14] = mk(CMD_WR, 8'h2D, 1, 8'h02, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[15] = mk(CMD_RD, 8'h01, 2, 8'h1D, 8'hF2, 8'h00, 8'h00, 1'b1);

    rst = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.csn  = 1'b1;
    spi_if.mosi = 1'b0;
    x_in = 12'hF85;
    y_in = 12'h123;
    z_in = 12'h800;
    clks(4);
    rst = 1'b0;
    clks(10);
    chk("reset_miso", spi_if.miso, 0);
    chk("reset_measure", measure, 0);
    chk("reset_frame_done", frame_done, 0);

    for (int i = 0; i < 16; i++) begin
      fd0 = fd_cnt;
      frame(tbl[i].cmd, tbl[i].addr, int'(tbl[i].n), tbl[i].d, rd);
      for (int j = 0; j < int'(tbl[i].n); j++)
        if (tbl[i].cmd == CMD_RD)
          chk($sformatf("vec%0d_byte%0d", i, j), rd[j], tbl[i].d[j]);
      chk($sformatf("vec%0d_measure", i), measure, tbl[i].meas);
      chk($sformatf("vec%0d_frame_done", i), fd_cnt - fd0, 1);
    end

    // reset in the middle of a read frame
    fd0 = fd_cnt;
    spi_if.csn = 1'b0;
    clks(6);
    xfer(CMD_RD, junk);
    xfer(8'h00, junk);
    clks(HALF);
    chk("rst_pre_miso", spi_if.miso, 1);
    chk("rst_pre_measure", measure, 1);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    chk("rst_miso", spi_if.miso, 0);
    chk("rst_measure", measure, 0);
    xfer(8'hFF, r0);
    chk("rst_ignore_miso", r0, 0);
    clks(4);
    spi_if.csn = 1'b1;
    clks(10);
    chk("rst_no_frame_done", fd_cnt - fd0, 0);
    frame(CMD_RD, 8'h2C, 2, '0, rd);
    chk("rst_filter", rd[0], 8'h13);
    chk("rst_power", rd[1], 8'h00);
    frame(CMD_RD, 8'h00, 1, '0, rd);
    chk("rst_next_frame", rd[0], 8'hAD);

    // write aborted after 5 data bits
    fd0 = fd_cnt;
    spi_if.csn = 1'b0;
    clks(6);
    xfer(CMD_WR, junk);
    xfer(8'h2C, junk);
    for (int i = 0; i < 5; i++) sbit(1'b1, rb);
    clks(HALF);
    spi_if.csn = 1'b1;
    clks(2);
    chk("abort_fd_early", frame_done, 0);
    clks(1);
    chk("abort_fd_pulse", frame_done, 1);
    clks(1);
    chk("abort_fd_width", frame_done, 0);
    clks(6);
    chk("abort_fd_count", fd_cnt - fd0, 1);
    frame(CMD_RD, 8'h2C, 1, '0, rd);
    chk("abort_filter", rd[0], 8'h13);

    // measure latency after the 8th data rise
    spi_if.csn = 1'b0;
    clks(6);
    xfer(CMD_WR, junk);
    xfer(ADDR_POWER, junk);
    for (int i = 7; i >= 1; i--) sbit((i == 1), rb);
    spi_if.mosi = 1'b0;
    clks(HALF);
    spi_if.sclk = 1'b1;
    clks(2);
    chk("meas_lat_early", measure, 0);
    clks(1);
    chk("meas_lat_on", measure, 1);
    clks(HALF - 3);
    spi_if.sclk = 1'b0;
    clks(4);
    spi_if.csn = 1'b1;
    clks(10);

    // snapshot coherence: x_in changes after csn fall
    spi_if.csn = 1'b0;
    clks(6);
    xfer(CMD_RD, junk);
    x_in = 12'h07A;
    xfer(ADDR_XDATA_L, junk);
    xfer(8'h00, r0);
    xfer(8'h00, r1);
    clks(4);
    spi_if.csn = 1'b1;
    clks(10);
    chk("snap_xl", r0, 8'h85);
    chk("snap_xh", r1, 8'hFF);
    frame(CMD_RD, ADDR_XDATA_L, 2, '0, rd);
    chk("new_xl", rd[0], 8'h7A);
    chk("new_xh", rd[1], 8'h00);

    // illegal command: miso silent, nothing written
    fd0 = fd_cnt;
    spi_if.csn = 1'b0;
    clks(6);
    xfer(8'h55, r0);
    chk("bad_cmd_b0", r0, 0);
    xfer(ADDR_POWER, r0);
    chk("bad_cmd_b1", r0, 0);
    xfer(8'h00, r0);
    chk("bad_cmd_b2", r0, 0);
    xfer(8'h00, r0);
    chk("bad_cmd_b3", r0, 0);
    clks(4);
    spi_if.csn = 1'b1;
    clks(10);
    chk("bad_cmd_fd", fd_cnt - fd0, 0);
    chk("bad_cmd_measure", measure, 1);
    frame(CMD_RD, ADDR_POWER, 1, '0, rd);
    chk("bad_cmd_power", rd[0], 8'h02);

    // data registers blank when not measuring
    frame(CMD_WR, ADDR_POWER, 1, '0, rd);
    chk("standby_measure", measure, 0);
    frame(CMD_RD, ADDR_XDATA_L, 2, '0, rd);
    chk("standby_xl", rd[0], 8'h00);
    chk("standby_xh", rd[1], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
